// File: rtl/cdc_arb_pkg.sv
// cdc_wr_arbiter shared types: FSM state, burst counter width,
// and round-robin pointer advance helper.
package cdc_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int BURST_W = 8;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/cdc_wr_arbiter_rr_pick.sv
// rr_pick: masked round-robin priority encoder. Scans from start,
// skipping excl when use_excl is set; reports first valid index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    input  logic [IW-1:0] excl,
    input  logic          use_excl,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int j;
        j     = 0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(start) + k) % N;
            if (!found && valid[j] &&
                !(use_excl && (IW'(j) == excl))) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cdc_wr_arbiter.sv
// cdc_wr_arbiter: burst round-robin share of the CDC FIFO write port.
// Optional ARB_STATS_EN adds transfer and full-stall counters.
module cdc_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk_a,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [ID_W+DATA_W-1:0]    fifo_wr_data,
    output logic [ID_W-1:0]           gnt_id,
    output logic                      gnt_active
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_xfer_cnt,
    output logic [15:0]               stat_stall_cnt
`endif
);

    import cdc_arb_pkg::*;

    state_t             state;
    state_t             state_nx;
    logic [ID_W-1:0]    gnt_nx;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    ptr_nx;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] cnt_nx;

    logic [ID_W-1:0]    nxt_id;
    logic [ID_W-1:0]    pick_start;
    logic [ID_W-1:0]    pick_id;
    logic               pick_found;
    logic               in_grant;
    logic               cur_valid;
    logic               xfer;
    logic               last;
    logic               rel;
    logic [DATA_W-1:0]  sel_data;

    assign nxt_id     = ID_W'(rr_next(int'(gnt_id), NUM_REQ));
    assign in_grant   = (state == GRANT);
    assign cur_valid  = req_valid[gnt_id];
    assign xfer       = in_grant & cur_valid & ~fifo_full;
    assign last       = (burst_cnt == BURST_W'(MAX_BURST - 1));
    assign rel        = in_grant & ((xfer & last) | ~cur_valid);
    assign pick_start = in_grant ? nxt_id : rr_ptr;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // In GRANT the current owner is excluded so others win first;
    // the owner is regranted only when nobody else is waiting.
    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .valid    (req_valid),
        .start    (pick_start),
        .excl     (gnt_id),
        .use_excl (in_grant),
        .idx      (pick_id),
        .found    (pick_found)
    );

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_id    <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            gnt_id    <= gnt_nx;
            rr_ptr    <= ptr_nx;
            burst_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_id;
        ptr_nx   = rr_ptr;
        cnt_nx   = burst_cnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nx = GRANT;
                    gnt_nx   = pick_id;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_nx = nxt_id;
                    cnt_nx = '0;
                    if (pick_found) begin
                        gnt_nx = pick_id;
                    end else if (!cur_valid) begin
                        state_nx = IDLE;
                    end
                end else if (xfer) begin
                    cnt_nx = burst_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = xfer;
        fifo_wr_data = '0;
        gnt_active   = in_grant;
        if (in_grant && !fifo_full) begin
            req_ready[gnt_id] = 1'b1;
        end
        if (xfer) begin
            fifo_wr_data = {gnt_id, sel_data};
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] xfer_cnt [NUM_REQ];
    logic [15:0] stall_cnt;

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                xfer_cnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && (gnt_id == ID_W'(i)) &&
                    (xfer_cnt[i] != 16'hFFFF)) begin
                    xfer_cnt[i] <= xfer_cnt[i] + 1'b1;
                end
            end
            if (in_grant && cur_valid && fifo_full &&
                (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_xfer_cnt[i*16 +: 16] = xfer_cnt[i];
        end
    end

    assign stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// tb_cdc_wr_arbiter: directed and random stimulus against a
// transaction-level round-robin burst model.
module tb_cdc_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int IW = 2;

    logic             clk_a = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N*DW-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [IW+DW-1:0] fifo_wr_data;
    logic [IW-1:0]    gnt_id;
    logic             gnt_active;
`ifdef ARB_STATS_EN
    logic [N*16-1:0]  stat_xfer_cnt;
    logic [15:0]      stat_stall_cnt;
`endif

    cdc_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk_a        (clk_a),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .gnt_id       (gnt_id),
        .gnt_active   (gnt_active)
`ifdef ARB_STATS_EN
        ,
        .stat_xfer_cnt  (stat_xfer_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk_a = ~clk_a;

    int total = 0;
    int bad   = 0;
    int rem [N];
    int cyc   = 0;
    int wr_src [$];
    int wr_cyc [$];

    bit m_act;
    int m_own;
    int m_cnt;
    int m_ptr;

    logic [N-1:0]     e_ready;
    bit               e_wr;
    logic [IW+DW-1:0] e_data;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int pick_from(input logic [N-1:0] v,
                                     input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_eval();
        e_ready = '0;
        e_wr    = 1'b0;
        e_data  = '0;
        if (m_act) begin
            if (!fifo_full) e_ready[m_own] = 1'b1;
            e_wr = req_valid[m_own] && !fifo_full;
            if (e_wr) e_data = {IW'(m_own), req_data[m_own*DW +: DW]};
        end
    endtask

    task automatic model_step();
        int p;
        if (!m_act) begin
            p = pick_from(req_valid, m_ptr);
            if (p >= 0) begin
                m_act = 1'b1;
                m_own = p;
                m_cnt = 0;
            end
        end else begin
            if (e_wr) m_cnt++;
            if ((e_wr && m_cnt == MB) || !req_valid[m_own]) begin
                m_ptr = (m_own + 1) % N;
                p = pick_from(req_valid, m_ptr);
                if (p >= 0) begin
                    m_own = p;
                    m_cnt = 0;
                end else begin
                    m_act = 1'b0;
                end
            end
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) req_valid[i] = (rem[i] > 0);
    endtask

    task automatic model_reset();
        m_act = 1'b0;
        m_own = 0;
        m_cnt = 0;
        m_ptr = 0;
    endtask

    task automatic step();
        logic [N-1:0] took;
        @(negedge clk_a);
        model_eval();
        check("ready", 64'(req_ready), 64'(e_ready));
        check("wr_en", 64'(fifo_wr_en), 64'(e_wr));
        check("wr_data", 64'(fifo_wr_data), 64'(e_data));
        check("active", 64'(gnt_active), 64'(m_act));
        check("gnt_id", 64'(gnt_id), 64'(m_own));
        if (fifo_wr_en) begin
            wr_src.push_back(int'(fifo_wr_data[IW+DW-1 -: IW]));
            wr_cyc.push_back(cyc);
        end
        took = e_ready & req_valid;
        @(posedge clk_a);
        model_step();
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (took[i]) begin
                rem[i]--;
                req_data[i*DW +: DW] = DW'($urandom);
            end
        end
        apply();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        apply();
        model_reset();
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        check("rst_active", 64'(gnt_active), 64'(0));
        repeat (2) @(posedge clk_a);
        #1;
        rst_n = 1'b1;
        wr_src.delete();
        wr_cyc.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        req_valid = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);

        // single requester 2, three words
        do_reset();
        rem[2] = 3;
        apply();
        c0 = cyc;
        step();
        check("t1_gnt", 64'(gnt_id), 64'(2));
        check("t1_act", 64'(gnt_active), 64'(1));
        repeat (5) step();
        check("t1_cnt", 64'(wr_src.size()), 64'(3));
        n = (wr_src.size() < 3) ? wr_src.size() : 3;
        for (int k = 0; k < n; k++) begin
            check("t1_src", 64'(wr_src[k]), 64'(2));
            check("t1_cyc", 64'(wr_cyc[k]), 64'(c0 + 1 + k));
        end
        check("t1_idle", 64'(gnt_active), 64'(0));

        // all valid: 0,1,2,3,0 bursts of MB, no gaps
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 100;
        apply();
        repeat (41) step();
        check("t2_cnt", 64'(wr_src.size() >= 33), 64'(1));
        n = (wr_src.size() < 33) ? wr_src.size() : 33;
        for (int k = 0; k < n; k++) begin
            check("t2_src", 64'(wr_src[k]), 64'((k / MB) % N));
            check("t2_gap", 64'(wr_cyc[k] - wr_cyc[0]), 64'(k));
        end

        // full stalls mid-burst on requester 1
        do_reset();
        rem[1] = 8;
        apply();
        repeat (4) step();
        fifo_full = 1'b1;
        repeat (5) step();
        fifo_full = 1'b0;
        repeat (10) step();
        check("t3_cnt", 64'(wr_src.size()), 64'(8));
        if (wr_src.size() == 8) begin
            check("t3_span", 64'(wr_cyc[7] - wr_cyc[0]), 64'(12));
            foreach (wr_src[k]) check("t3_src", 64'(wr_src[k]), 64'(1));
        end

        // requester 0 drops after 3 words, 3 waiting
        do_reset();
        rem[0] = 3;
        rem[3] = 20;
        apply();
        repeat (5) step();
        check("t4_gnt", 64'(gnt_id), 64'(3));
        check("t4_act", 64'(gnt_active), 64'(1));

        // async reset mid-burst
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 50;
        apply();
        repeat (12) step();
        check("t5_pre", 64'(gnt_id), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_ready", 64'(req_ready), 64'(0));
        check("t5_wr_en", 64'(fifo_wr_en), 64'(0));
        check("t5_data", 64'(fifo_wr_data), 64'(0));
        check("t5_act", 64'(gnt_active), 64'(0));
        check("t5_gnt", 64'(gnt_id), 64'(0));
        model_reset();
        @(posedge clk_a);
        #1;
        rst_n = 1'b1;
        step();
        check("t5_post", 64'(gnt_id), 64'(0));
        check("t5_post_act", 64'(gnt_active), 64'(1));

        // random traffic, drops and back-pressure
        do_reset();
        repeat (800) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && ($urandom % 4) == 0)
                    rem[i] = $urandom_range(1, 12);
                else if (rem[i] > 0 && ($urandom % 50) == 0)
                    rem[i] = 0;
            end
            fifo_full = (($urandom % 5) == 0);
            apply();
            step();
        end

`ifdef ARB_STATS_EN
        do_reset();
        rem[1] = 100;
        apply();
        repeat (10) step();
        fifo_full = 1'b1;
        repeat (7) step();
        fifo_full = 1'b0;
        repeat (100) step();
        check("st_xfer1", 64'(stat_xfer_cnt[16 +: 16]), 64'(100));
        check("st_xfer0", 64'(stat_xfer_cnt[0 +: 16]), 64'(0));
        check("st_stall", 64'(stat_stall_cnt), 64'(7));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_wr_arbiter.md
# cdc_wr_arbiter

Round-robin scheduler that shares the single write port of the clk_a-side CDC FIFO among NUM_REQ producers in the clk_a domain. Grants are held for bursts of up to MAX_BURST words to amortise arbitration. Each accepted word is tagged with its source index so the clk_b consumer can demultiplex. FIFO full back-pressures the granted requester only.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 16: payload width per requester.
- MAX_BURST, 8: max words per grant (1..255).
- ID_W, $clog2(NUM_REQ): source tag width (derived).
- clk_a  in  1  write-domain clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_W  packed payloads; requester i at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- fifo_full  in  1  CDC FIFO write-side full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  ID_W+DATA_W  {source id, payload}.
- gnt_id  out  ID_W  current grant owner; valid when gnt_active.
- gnt_active  out  1  high in GRANT state.

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if any req_valid, select first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; load gnt_id, clear burst_cnt, go GRANT next cycle. No transfer in IDLE.
- GRANT: req_ready[gnt_id] = !fifo_full; all other ready bits 0.
- Transfer = req_valid[gnt_id] & req_ready[gnt_id]; fifo_wr_en = transfer (combinational); fifo_wr_data = {gnt_id, req_data[gnt_id]}.
- burst_cnt (8 bit) increments per transfer.
- Release when (transfer && burst_cnt == MAX_BURST-1) or (!req_valid[gnt_id]).
- On release: rr_ptr <= gnt_id+1 mod NUM_REQ; re-arbitrate in the same edge from the new rr_ptr, excluding gnt_id if any other requester is valid; if none other valid and gnt_id still valid, regrant gnt_id; if none valid, go IDLE.
- fifo_full in GRANT stalls without releasing; burst_cnt holds.
- Requesters must hold req_valid/req_data stable until ready (AXI-stream rule); dropping valid without a transfer is treated as release.

## Timing
- Reset values: req_ready=0, fifo_wr_en=0, fifo_wr_data=0 (gated), gnt_id=0, gnt_active=0, rr_ptr=0, burst_cnt=0, state=IDLE.
- IDLE->first transfer latency: 1 cycle (grant registered, transfer on next edge).
- Back-to-back grants across release: zero bubble.
- fifo_wr_en follows fifo_full combinationally in the same cycle; no write ever issues while fifo_full=1.
- Reset asserted mid-burst: all outputs go to reset values immediately (asynchronous); in-flight word not written.
- Fairness: with all requesters continuously valid and FIFO never full, each gets exactly MAX_BURST words per NUM_REQ*MAX_BURST cycles.

## Configuration
- ARB_STATS_EN defined: adds per-requester 16-bit saturating grant counters (incremented on each transfer) and a 16-bit full-stall counter, exposed as output stat_xfer_cnt (NUM_REQ*16) and stat_stall_cnt (16); reset to 0.
- Undefined: ports and counters absent; arbitration behaviour identical.

## Structure
- Package cdc_arb_pkg: state enum (IDLE, GRANT), MAX_BURST width constant, rr_next function.
- One sub-module: rr_pick (combinational masked round-robin priority encoder: valid vector + start pointer + exclude index -> index + found flag).

## Test plan
- Single requester 2 valid for 3 words, FIFO empty -> gnt_id=2 after 1 cycle, 3 writes of {2,data} on consecutive cycles, then IDLE.
- All 4 valid continuously, MAX_BURST=8 -> grant order 0,1,2,3,0, each exactly 8 writes, no gap cycles.
- fifo_full asserted 5 cycles mid-burst on requester 1 -> fifo_wr_en=0 and req_ready=0 those cycles, burst resumes, still 8 total words.
- Requester 0 drops valid after 3 words while 3 valid -> release, next cycle gnt_id=3, rr_ptr=1.
- rst_n pulsed low mid-burst -> outputs zero within same cycle, post-reset grant starts at index 0.
- ARB_STATS_EN: 100 transfers from requester 1 with 7 full cycles -> stat_xfer_cnt[1]=100, stat_stall_cnt=7.
